// File: rtl/bp_nonsynth_host_mmio.sv
// Host MMIO endpoint: in-order command queue, single response register, getchar/putchar FIFOs,
// per-core finish/pass tracking, a free-running cycle counter and an illegal-domain counter.
module bp_nonsynth_host_mmio #(
  parameter int unsigned paddr_width_p          = 40,
  parameter int unsigned cce_block_width_p      = 128,
  parameter int unsigned num_core_p             = 2,
  parameter int unsigned dword_width_p          = 64,
  parameter int unsigned mem_hdr_width_p        = 64,
  parameter int unsigned host_max_outstanding_p = 8,
  parameter int unsigned getchar_els_p          = 4,
  parameter int unsigned putch_els_p            = 8,
  parameter bit          finish_first_only_p    = 1'b1,
  localparam int unsigned cce_mem_msg_width_lp  = mem_hdr_width_p + cce_block_width_p,
  localparam int unsigned lg_num_core_lp        = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,
  input  logic [7:0]                      getchar_data_i,
  input  logic                            getchar_v_i,
  output logic                            getchar_ready_o,
  output logic                            putch_global_o,
  output logic [lg_num_core_lp-1:0]       putch_core_o,
  output logic [7:0]                      putch_data_o,
  output logic                            putch_v_o,
  input  logic                            putch_yumi_i,
  output logic [num_core_p-1:0]           finish_o,
  output logic [num_core_p-1:0]           pass_o,
  output logic                            all_finished_o,
  output logic [15:0]                     illegal_cnt_o
);

  localparam int unsigned cmd_pw_lp = (host_max_outstanding_p > 1) ? $clog2(host_max_outstanding_p) : 1;
  localparam int unsigned cmd_cw_lp = $clog2(host_max_outstanding_p + 1);
  localparam int unsigned gc_pw_lp  = (getchar_els_p > 1) ? $clog2(getchar_els_p) : 1;
  localparam int unsigned gc_cw_lp  = $clog2(getchar_els_p + 1);
  localparam int unsigned pc_pw_lp  = (putch_els_p > 1) ? $clog2(putch_els_p) : 1;
  localparam int unsigned pc_cw_lp  = $clog2(putch_els_p + 1);
  localparam int unsigned pc_w_lp   = 1 + lg_num_core_lp + 8;

  // ---------------- command FIFO ----------------
  logic [cce_mem_msg_width_lp-1:0] r_cmd_mem [host_max_outstanding_p];
  logic [cmd_pw_lp-1:0]            r_cmd_wptr, r_cmd_rptr;
  logic [cmd_cw_lp-1:0]            r_cmd_cnt;
  logic                            w_cmd_enq, w_head_v, w_deq;
  logic [cce_mem_msg_width_lp-1:0] w_head;

  assign io_cmd_ready_o = (r_cmd_cnt != cmd_cw_lp'(host_max_outstanding_p));
  assign w_cmd_enq      = io_cmd_v_i & io_cmd_ready_o;
  assign w_head_v       = (r_cmd_cnt != '0);
  assign w_head         = r_cmd_mem[r_cmd_rptr];

  always_ff @(posedge clk_i) begin
    if (w_cmd_enq) r_cmd_mem[r_cmd_wptr] <= io_cmd_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cmd_wptr <= '0;
      r_cmd_rptr <= '0;
      r_cmd_cnt  <= '0;
    end else begin
      if (w_cmd_enq) begin
        r_cmd_wptr <= (r_cmd_wptr == cmd_pw_lp'(host_max_outstanding_p - 1)) ? '0
                    : r_cmd_wptr + cmd_pw_lp'(1);
      end
      if (w_deq) begin
        r_cmd_rptr <= (r_cmd_rptr == cmd_pw_lp'(host_max_outstanding_p - 1)) ? '0
                    : r_cmd_rptr + cmd_pw_lp'(1);
      end
      r_cmd_cnt <= r_cmd_cnt + cmd_cw_lp'(w_cmd_enq) - cmd_cw_lp'(w_deq);
    end
  end

  // ---------------- head decode ----------------
  logic [mem_hdr_width_p-1:0]      w_hdr;
  logic [paddr_width_p-1:0]        w_addr;
  logic [7:0]                      w_wbyte;
  logic [lg_num_core_lp-1:0]       w_core;
  logic                            w_core_ok, w_hi_zero, w_illegal;
  logic                            w_getc, w_putc, w_finish, w_putcore, w_cycle;
  logic                            w_unused_data;

  assign w_hdr         = w_head[mem_hdr_width_p-1:0];
  assign w_addr        = w_hdr[paddr_width_p-1:0];
  assign w_wbyte       = w_head[mem_hdr_width_p +: 8];
  assign w_unused_data = ^w_head[cce_mem_msg_width_lp-1:mem_hdr_width_p+8];
  assign w_core        = w_addr[3 +: lg_num_core_lp];
  assign w_core_ok     = (32'(w_core) < num_core_p);
  assign w_hi_zero     = (w_addr[paddr_width_p-1:32] == '0);
  assign w_illegal     = (w_addr[paddr_width_p-1 -: 3] != 3'b000);

  always_comb begin
    w_getc    = 1'b0;
    w_putc    = 1'b0;
    w_finish  = 1'b0;
    w_putcore = 1'b0;
    w_cycle   = 1'b0;
    if (!w_illegal) begin
      casez ({w_hi_zero, w_addr[31:0]})
        33'h1_0010_0000: w_getc    = 1'b1;
        33'h1_0010_1000: w_putc    = 1'b1;
        33'h1_0010_2???: w_finish  = 1'b1;
        33'h1_0010_3???: w_putcore = 1'b1;
        33'h1_0010_4000: w_cycle   = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- getchar FIFO ----------------
  logic [7:0]          r_gc_mem [getchar_els_p];
  logic [gc_pw_lp-1:0] r_gc_wptr, r_gc_rptr;
  logic [gc_cw_lp-1:0] r_gc_cnt;
  logic                w_gc_push, w_gc_pop, w_gc_v;

  assign getchar_ready_o = (r_gc_cnt != gc_cw_lp'(getchar_els_p));
  assign w_gc_push       = getchar_v_i & getchar_ready_o;
  assign w_gc_v          = (r_gc_cnt != '0);
  assign w_gc_pop        = w_deq & w_getc & w_gc_v;

  always_ff @(posedge clk_i) begin
    if (w_gc_push) r_gc_mem[r_gc_wptr] <= getchar_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_gc_wptr <= '0;
      r_gc_rptr <= '0;
      r_gc_cnt  <= '0;
    end else begin
      if (w_gc_push) begin
        r_gc_wptr <= (r_gc_wptr == gc_pw_lp'(getchar_els_p - 1)) ? '0 : r_gc_wptr + gc_pw_lp'(1);
      end
      if (w_gc_pop) begin
        r_gc_rptr <= (r_gc_rptr == gc_pw_lp'(getchar_els_p - 1)) ? '0 : r_gc_rptr + gc_pw_lp'(1);
      end
      r_gc_cnt <= r_gc_cnt + gc_cw_lp'(w_gc_push) - gc_cw_lp'(w_gc_pop);
    end
  end

  // ---------------- putchar FIFO ----------------
  logic [pc_w_lp-1:0]  r_pc_mem [putch_els_p];
  logic [pc_pw_lp-1:0] r_pc_wptr, r_pc_rptr;
  logic [pc_cw_lp-1:0] r_pc_cnt;
  logic                w_pc_push, w_pc_pop, w_pc_full, w_wants_putch, w_stall;
  logic [pc_w_lp-1:0]  w_pc_din;

  assign w_pc_full     = (r_pc_cnt == pc_cw_lp'(putch_els_p));
  assign w_wants_putch = w_putc | (w_putcore & w_core_ok);
  // A character command at the head waits for FIFO space; nothing behind it may overtake.
  assign w_stall       = w_wants_putch & w_pc_full;
  assign w_deq         = w_head_v & (~io_resp_v_o | io_resp_yumi_i) & ~w_stall;
  assign w_pc_push     = w_deq & w_wants_putch;
  assign w_pc_din      = w_putc ? {1'b1, lg_num_core_lp'(0), w_wbyte} : {1'b0, w_core, w_wbyte};
  assign putch_v_o     = (r_pc_cnt != '0);
  assign w_pc_pop      = putch_v_o & putch_yumi_i;
  assign {putch_global_o, putch_core_o, putch_data_o} = r_pc_mem[r_pc_rptr];

  always_ff @(posedge clk_i) begin
    if (w_pc_push) r_pc_mem[r_pc_wptr] <= w_pc_din;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc_wptr <= '0;
      r_pc_rptr <= '0;
      r_pc_cnt  <= '0;
    end else begin
      if (w_pc_push) begin
        r_pc_wptr <= (r_pc_wptr == pc_pw_lp'(putch_els_p - 1)) ? '0 : r_pc_wptr + pc_pw_lp'(1);
      end
      if (w_pc_pop) begin
        r_pc_rptr <= (r_pc_rptr == pc_pw_lp'(putch_els_p - 1)) ? '0 : r_pc_rptr + pc_pw_lp'(1);
      end
      r_pc_cnt <= r_pc_cnt + pc_cw_lp'(w_pc_push) - pc_cw_lp'(w_pc_pop);
    end
  end

  // ---------------- response register and status ----------------
  logic [cce_mem_msg_width_lp-1:0] r_resp;
  logic                            r_resp_v;
  logic [cce_block_width_p-1:0]    w_rdata;
  logic [63:0]                     r_cycle;
  logic [num_core_p-1:0]           r_finish, r_pass;
  logic                            r_all_fin;
  logic [15:0]                     r_illegal;

  always_comb begin
    w_rdata = '0;
    if (w_getc) begin
      w_rdata[dword_width_p-1:0] = w_gc_v ? dword_width_p'(r_gc_mem[r_gc_rptr]) : '1;
    end else if (w_cycle) begin
      w_rdata[dword_width_p-1:0] = dword_width_p'(r_cycle);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_resp_v <= 1'b0;
      r_resp   <= '0;
    end else if (w_deq) begin
      r_resp_v <= 1'b1;
      r_resp   <= {w_rdata, w_hdr};
    end else if (io_resp_yumi_i) begin
      r_resp_v <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cycle   <= '0;
      r_finish  <= '0;
      r_pass    <= '0;
      r_all_fin <= 1'b0;
      r_illegal <= '0;
    end else begin
      r_cycle   <= r_cycle + 64'd1;
      r_all_fin <= r_all_fin | (&r_finish);
      if (w_deq && w_finish && w_core_ok) begin
        r_finish[w_core] <= 1'b1;
        if (!finish_first_only_p || !r_finish[w_core]) r_pass[w_core] <= (w_wbyte == 8'h00);
      end
      if (w_deq && w_illegal && (r_illegal != 16'hFFFF)) r_illegal <= r_illegal + 16'd1;
    end
  end

  assign io_resp_o      = r_resp;
  assign io_resp_v_o    = r_resp_v;
  assign finish_o       = r_finish;
  assign pass_o         = r_pass;
  assign all_finished_o = r_all_fin;
  assign illegal_cnt_o  = r_illegal;

endmodule

// File: tb/tb_bp_nonsynth_host_mmio.sv
// Directed bench for bp_nonsynth_host_mmio: scoreboarded responses and output characters,
// plus point checks on latency, stall, finish/pass, illegal count, cycle counter and reset flush.
module tb_bp_nonsynth_host_mmio;
  localparam int PA = 40;
  localparam int BW = 128;
  localparam int HW = 64;
  localparam int MW = HW + BW;
  localparam int NC = 2;
  localparam int LG = 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [MW-1:0] io_cmd_i = '0;
  logic          io_cmd_v_i = 1'b0;
  logic          io_cmd_ready_o;
  logic [MW-1:0] io_resp_o;
  logic          io_resp_v_o;
  logic          io_resp_yumi_i;
  logic [7:0]    getchar_data_i = '0;
  logic          getchar_v_i = 1'b0;
  logic          getchar_ready_o;
  logic          putch_global_o;
  logic [LG-1:0] putch_core_o;
  logic [7:0]    putch_data_o;
  logic          putch_v_o;
  logic          putch_yumi_i;
  logic [NC-1:0] finish_o, pass_o;
  logic          all_finished_o;
  logic [15:0]   illegal_cnt_o;

  bit resp_en = 1'b0;
  bit putch_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n_resp = 0;
  logic [63:0] tb_cyc;
  logic [MW-1:0] sb[$];
  logic [9:0] psb[$];

  always #5 clk = ~clk;

  assign io_resp_yumi_i = io_resp_v_o & resp_en;
  assign putch_yumi_i   = putch_v_o & putch_en;

  bp_nonsynth_host_mmio #(
    .paddr_width_p(PA), .cce_block_width_p(BW), .num_core_p(NC), .dword_width_p(64),
    .mem_hdr_width_p(HW), .host_max_outstanding_p(8), .getchar_els_p(4), .putch_els_p(8),
    .finish_first_only_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .getchar_data_i(getchar_data_i), .getchar_v_i(getchar_v_i),
    .getchar_ready_o(getchar_ready_o),
    .putch_global_o(putch_global_o), .putch_core_o(putch_core_o), .putch_data_o(putch_data_o),
    .putch_v_o(putch_v_o), .putch_yumi_i(putch_yumi_i),
    .finish_o(finish_o), .pass_o(pass_o), .all_finished_o(all_finished_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  // Reference cycle count: edges seen with reset low since the last reset edge.
  always @(posedge clk) tb_cyc <= reset_i ? 64'd0 : tb_cyc + 64'd1;

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [PA-1:0] a, input logic [7:0] tag);
    return {tag, 16'h0000, a};
  endfunction

  always @(negedge clk) begin
    if (!reset_i && io_resp_v_o && io_resp_yumi_i) begin
      n_resp++;
      if (sb.size() == 0) check("resp_unexpected", MW'(sb.size()), MW'(1));
      else check("resp", io_resp_o, sb.pop_front());
    end
    if (!reset_i && putch_v_o && putch_yumi_i) begin
      if (psb.size() == 0) check("putch_unexpected", MW'(psb.size()), MW'(1));
      else check("putch", MW'({putch_global_o, putch_core_o, putch_data_o}), MW'(psb.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PA-1:0] a, input logic [7:0] tag, input logic [BW-1:0] wd,
                      input logic [BW-1:0] rd, input bit exp_resp);
    int g = 0;
    while (!io_cmd_ready_o && g < 300) begin
      tick(1);
      g++;
    end
    if (g >= 300) check("cmd_ready_timeout", MW'(io_cmd_ready_o), MW'(1));
    io_cmd_i   = {wd, mk_hdr(a, tag)};
    io_cmd_v_i = 1'b1;
    if (exp_resp) sb.push_back({rd, mk_hdr(a, tag)});
    tick(1);
    io_cmd_v_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((sb.size() != 0 || psb.size() != 0) && g < 500) begin
      tick(1);
      g++;
    end
    check(tag, MW'(sb.size() + psb.size()), MW'(0));
  endtask

  initial begin
    int base;
    logic [63:0] exp_cyc;
    tick(3);
    reset_i = 1'b0;
    check("rst_resp_v", MW'(io_resp_v_o), MW'(0));
    check("rst_putch_v", MW'(putch_v_o), MW'(0));
    check("rst_finish", MW'({finish_o, pass_o, all_finished_o}), MW'(0));
    check("rst_illegal", MW'(illegal_cnt_o), MW'(0));
    check("rst_cmd_ready", MW'(io_cmd_ready_o), MW'(1));

    // getchar: latency t+2, then empty FIFO returns all ones
    getchar_data_i = 8'h41;
    getchar_v_i    = 1'b1;
    tick(1);
    getchar_v_i = 1'b0;
    send(40'h00_0010_0000, 8'h11, {64'hDEAD_BEEF_0000_0001, 64'h0}, BW'(8'h41), 1'b1);
    check("getc_lat_t1", MW'(io_resp_v_o), MW'(0));
    tick(1);
    check("getc_lat_t2", MW'(io_resp_v_o), MW'(1));
    check("getc_data", io_resp_o, {BW'(8'h41), mk_hdr(40'h00_0010_0000, 8'h11)});
    resp_en = 1'b1;
    send(40'h00_0010_0000, 8'h12, '0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
    drain("getc_drain");

    // putch_core backpressure: 8 accepted, 9th stalls the head
    base = n_resp;
    for (int i = 0; i < 10; i++) begin
      send(40'h00_0010_3008, 8'(8'h20 + i), BW'(8'h61 + i), '0, 1'b1);
      psb.push_back({1'b0, 1'b1, 8'(8'h61 + i)});
    end
    tick(12);
    check("stall_resp_cnt", MW'(n_resp - base), MW'(8));
    check("stall_resp_v", MW'(io_resp_v_o), MW'(0));
    check("stall_putch_v", MW'(putch_v_o), MW'(1));
    putch_en = 1'b1;
    drain("putch_drain");
    check("putch_resp_cnt", MW'(n_resp - base), MW'(10));

    // finish core 0 pass, core 1 fail; all_finished one cycle after finish_o fills
    send(40'h00_0010_2000, 8'h30, BW'(8'h00), '0, 1'b1);
    send(40'h00_0010_2008, 8'h31, BW'(8'h03), '0, 1'b1);
    check("fin_d0", MW'({finish_o, all_finished_o}), MW'({2'b01, 1'b0}));
    tick(1);
    check("fin_d1", MW'({finish_o, pass_o, all_finished_o}), MW'({2'b11, 2'b01, 1'b0}));
    tick(1);
    check("fin_d2_all", MW'(all_finished_o), MW'(1));
    send(40'h00_0010_2000, 8'h32, BW'(8'h05), '0, 1'b1);
    tick(3);
    check("fin_sticky_pass", MW'({finish_o, pass_o}), MW'({2'b11, 2'b01}));

    // illegal domain aimed at putchar, and an unmapped address
    send(40'h40_0010_1000, 8'h40, BW'(8'h55), '0, 1'b1);
    send(40'h00_0010_5000, 8'h41, BW'(8'h56), '0, 1'b1);
    drain("illegal_drain");
    check("illegal_cnt", MW'(illegal_cnt_o), MW'(1));
    check("illegal_no_putch", MW'(putch_v_o), MW'(0));
    check("illegal_no_finish", MW'({finish_o, pass_o}), MW'({2'b11, 2'b01}));

    // cycle counter read 100 cycles after reset
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check("rst2_finish", MW'({finish_o, all_finished_o, illegal_cnt_o}), MW'(0));
    tick(100);
    exp_cyc = tb_cyc + 64'd1;
    send(40'h00_0010_4000, 8'h50, '0, BW'(exp_cyc), 1'b1);
    drain("cycle_drain");

    // reset discards queued commands and the pending response
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) send(40'h00_0010_0000, 8'(8'h60 + i), '0, '0, 1'b0);
    check("flush_pre_v", MW'(io_resp_v_o), MW'(1));
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check("flush_ready", MW'(io_cmd_ready_o), MW'(1));
    check("flush_resp_v", MW'(io_resp_v_o), MW'(0));
    base    = n_resp;
    resp_en = 1'b1;
    tick(20);
    check("flush_no_resp", MW'(n_resp - base), MW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bp_nonsynth_host_mmio.md
Name: bp_nonsynth_host_mmio

Overview:
- Parametrised host MMIO endpoint for the BedRock CCE mem I/O port in multicore testbenches; next generation of the nonsynth host block.
- Decodes host commands: getchar, global putchar, per-core putchar, finish, cycle counter, plus loopback for illegal domains.
- Character I/O goes through bounded FIFOs with valid/ready handshakes instead of direct DPI/file side effects, so backpressure, ordering and pass/fail status are observable at ports.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, cce_block_width_p, num_core_p, dword_width_p and cce_mem_msg_width_lp.
- host_max_outstanding_p, 8, command FIFO depth; must be ≥ 2.
- getchar_els_p, 4, input character FIFO depth.
- putch_els_p, 8, output character FIFO depth.
- finish_first_only_p, 1, 1 = first finish write per core is sticky; 0 = later writes overwrite pass/fail.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- io_cmd_i  in  cce_mem_msg_width_lp  BedRock mem command.
- io_cmd_v_i  in  1  command valid.
- io_cmd_ready_o  out  1  command FIFO not full.
- io_resp_o  out  cce_mem_msg_width_lp  response; header echoes the command header.
- io_resp_v_o  out  1  response valid.
- io_resp_yumi_i  in  1  response consumed.
- getchar_data_i  in  8  host character in.
- getchar_v_i  in  1  host character valid.
- getchar_ready_o  out  1  getchar FIFO not full.
- putch_global_o  out  1  1 = global putchar, 0 = per-core.
- putch_core_o  out  `BSG_SAFE_CLOG2(num_core_p)  source core id.
- putch_data_o  out  8  character.
- putch_v_o  out  1  output character valid.
- putch_yumi_i  in  1  output character consumed.
- finish_o  out  num_core_p  sticky per-core finished.
- pass_o  out  num_core_p  per-core pass; meaningful only where finish_o is set.
- all_finished_o  out  1  all cores finished.
- illegal_cnt_o  out  16  saturating illegal-domain access count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, reset_i).
- Reset values: all FIFOs empty; io_resp_v_o=0; putch_v_o=0; finish_o=0; pass_o=0; all_finished_o=0; illegal_cnt_o=0; cycle counter=0.
- Command path: io_cmd_i is enqueued when io_cmd_v_i & io_cmd_ready_o.
- Response register: one entry. The FIFO head is dequeued into it when the head is valid, the register is empty or io_resp_yumi_i is high this cycle, and the head is not stalled.
- Side effects fire only in the dequeue cycle. Minimum latency is enqueue at cycle t to io_resp_v_o at t+2. Throughput is 1 response/cycle under continuous yumi.
- Decode (casez on header.addr):
  - Illegal domain: domain = addr[paddr_width_p-1-:3] ≠ 0. Checked first; response data 0; illegal_cnt_o += 1, saturating at 16'hFFFF; no other side effect.
  - 0x0010_0000 getchar: data = zero-extended byte and the getchar FIFO pops if non-empty; otherwise data = all ones (-1).
  - 0x0010_1000 putchar: push {1, 0, data[7:0]} into the output FIFO.
  - 0x0010_2??? finish: core = addr[3+:lg_num_core]. Set finish[core]; pass[core] = (data[7:0]==0), subject to finish_first_only_p.
  - 0x0010_3??? putch_core: push {0, core, data[7:0]}.
  - 0x0010_4000 cycle: data = 64-bit cycle counter value in the dequeue cycle. The counter increments every non-reset cycle and wraps at 2^64.
  - Anything else: data 0, no side effect.
- Stall: putchar or putch_core at the head while the output FIFO is full is not dequeued until space exists. Strict in-order responses; no bypass of the stalled head.
- Same-cycle push and pop on either character FIFO is legal when full or empty as far as bsg_fifo_1r1w_small permits. Getchar on an empty FIFO never pops.
- Output data width: response data fields wider than 64 bits are zero-filled above bit 63.
- all_finished_o is registered: it asserts the cycle after &finish_o becomes 1 and stays set until reset.
- Finish core index ≥ num_core_p (non-power-of-2 core count) is ignored; the response is still sent.
- Reset asserted mid-operation discards all queued commands, the pending response and characters; no response for discarded commands.
- Out-of-range core ids are ignored.

Test Plan:
- Single getchar with FIFO holding 0x41 -> io_resp_v_o at t+2, data 0x41, FIFO empties; second getchar -> data 0xFFFF_FFFF_FFFF_FFFF.
- 10 putch_core writes, core 1, chars 'a'..'j', putch_yumi_i=0 -> 8 accepted, 9th stalls, io_resp_v_o stays low; then yumi every cycle -> chars emerge in order with core=1, all 10 responses return in order.
- num_core_p=2: finish core 0 data 0, then core 1 data 3 -> finish_o=2'b11, pass_o=2'b01; all_finished_o rises exactly one cycle after the second dequeue.
- Second finish to core 0 with data 5, finish_first_only_p=1 -> pass_o[0] stays 1.
- Command with addr domain 3'b010 -> data 0, illegal_cnt_o=1; no putch/finish activity.
- Cycle read issued 100 cycles after reset with no backpressure -> returned value equals the dequeue cycle index; assert reset with 3 commands queued -> no responses, io_cmd_ready_o=1 the next cycle.
